// File: rtl/line_writeback_serializer_if.sv
// Bus bundle between the eviction path, the write-back serializer and the memory write-back port.
interface line_writeback_serializer_if #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned SETS   = 64
);
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned SET_W = $clog2(SETS);

  logic                    in_valid;
  logic                    in_ready;
  logic [SETS-1:0]         in_set_onehot;
  logic [WORDS-1:0]        in_word_mask;
  logic [WORDS*WORD_W-1:0] in_line;
  logic                    out_valid;
  logic                    out_ready;
  logic [SET_W-1:0]        out_set;
  logic [OFF_W-1:0]        out_offset;
  logic [WORD_W-1:0]       out_data;
  logic                    out_last;
  logic                    err_onehot;

  modport slave (
    input  in_valid, in_set_onehot, in_word_mask, in_line, out_ready,
    output in_ready, out_valid, out_set, out_offset, out_data, out_last, err_onehot
  );

  modport master (
    output in_valid, in_set_onehot, in_word_mask, in_line, out_ready,
    input  in_ready, out_valid, out_set, out_offset, out_data, out_last, err_onehot
  );
endinterface

// File: rtl/line_writeback_serializer.sv
// Drains an evicted cache line for write-back: encodes the one-hot set and emits
// only the dirty words, lowest offset first, one per beat.
module line_writeback_serializer #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned SETS   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  line_writeback_serializer_if.slave   bus_io
);
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned SET_W = $clog2(SETS);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [WORDS-1:0]             mask_q, mask_d;
  logic [WORDS-1:0][WORD_W-1:0] line_q, line_d;
  logic [SET_W-1:0]             set_q, set_d;
  logic                         err_q, err_d;
  logic                         valid_q, valid_d;
  logic [OFF_W-1:0]             offset_q, offset_d;
  logic [WORD_W-1:0]            data_q, data_d;
  logic                         last_q, last_d;
  logic                         set_ok;

  function automatic logic [SET_W-1:0] encode_set(input logic [SETS-1:0] v);
    logic [SET_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(SETS); i++) begin
      if (v[i]) idx = idx | SET_W'(i);
    end
    return idx;
  endfunction

  // Lowest set bit wins: scan from the top so lower indices overwrite.
  function automatic logic [OFF_W-1:0] lowest_bit(input logic [WORDS-1:0] m);
    logic [OFF_W-1:0] idx;
    idx = '0;
    for (int i = int'(WORDS) - 1; i >= 0; i--) begin
      if (m[i]) idx = OFF_W'(i);
    end
    return idx;
  endfunction

  assign set_ok = (bus_io.in_set_onehot != '0) &&
                  ((bus_io.in_set_onehot & (bus_io.in_set_onehot - SETS'(1))) == '0);

  assign bus_io.in_ready   = (state_q == IDLE);
  assign bus_io.out_valid  = valid_q;
  assign bus_io.out_set    = set_q;
  assign bus_io.out_offset = offset_q;
  assign bus_io.out_data   = data_q;
  assign bus_io.out_last   = last_q;
  assign bus_io.err_onehot = err_q;

  // Next-state and next-output: beat outputs are precomputed from the next mask.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    line_d  = line_q;
    set_d   = set_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          if (!set_ok) begin
            err_d = 1'b1;
          end else if (bus_io.in_word_mask != '0) begin
            mask_d  = bus_io.in_word_mask;
            line_d  = bus_io.in_line;
            set_d   = encode_set(bus_io.in_set_onehot);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus_io.out_ready) begin
          mask_d = mask_q & ~(WORDS'(1) << offset_q);
          if (last_q) begin
            state_d = IDLE;
            set_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d  = (state_d == DRAIN);
    offset_d = valid_d ? lowest_bit(mask_d) : '0;
    data_d   = valid_d ? line_d[offset_d] : '0;
    last_d   = valid_d && (mask_d != '0) && ((mask_d & (mask_d - WORDS'(1))) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      line_q   <= '0;
      set_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      offset_q <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      line_q   <= line_d;
      set_q    <= set_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      offset_q <= offset_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end
endmodule

// File: tb/tb_line_writeback_serializer.sv
// Directed, table-driven bench for line_writeback_serializer with reset and stall sequences.
module tb_line_writeback_serializer;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  line_writeback_serializer_if bus ();

  line_writeback_serializer dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] set_oh;
    logic [7:0]  mask;
    logic        err;
    logic [5:0]  set_idx;
    int          nbeats;
    logic [31:0] offs;   // nibble b = offset of beat b
    logic        stall;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] make_line(input int v);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = 64'hA0 + 64'(i) + (64'(v) << 32);
    return l;
  endfunction

  function automatic logic [63:0] word_of(input int v, input int off);
    return 64'hA0 + 64'(off) + (64'(v) << 32);
  endfunction

  task automatic run_vec(input int v);
    vec_t t;
    int   off;
    t = vecs[v];
    chk($sformatf("v%0d_ready_idle", v), 64'(bus.in_ready), 64'd1);
    bus.in_valid      = 1'b1;
    bus.in_set_onehot = t.set_oh;
    bus.in_word_mask  = t.mask;
    bus.in_line       = make_line(v);
    bus.out_ready     = 1'b1;
    step();
    if (t.nbeats > 0) begin
      // Keep a different request on the bus while draining; it must be ignored.
      bus.in_set_onehot = 64'h2;
      bus.in_word_mask  = 8'hFF;
      bus.in_line       = make_line(99);
    end else begin
      bus.in_valid = 1'b0;
    end
    chk($sformatf("v%0d_err", v), 64'(bus.err_onehot), 64'(t.err));
    if (t.nbeats == 0) begin
      chk($sformatf("v%0d_novalid", v), 64'(bus.out_valid), 64'd0);
      chk($sformatf("v%0d_ready_stay", v), 64'(bus.in_ready), 64'd1);
      step();
      chk($sformatf("v%0d_err_pulse_end", v), 64'(bus.err_onehot), 64'd0);
      chk($sformatf("v%0d_novalid2", v), 64'(bus.out_valid), 64'd0);
    end else begin
      for (int b = 0; b < t.nbeats; b++) begin
        off = int'((t.offs >> (4 * b)) & 32'h7);
        if (t.stall) begin
          bus.out_ready = 1'b0;
          chk($sformatf("v%0d_b%0d_stall_off", v, b), 64'(bus.out_offset), 64'(off));
          chk($sformatf("v%0d_b%0d_stall_valid", v, b), 64'(bus.out_valid), 64'd1);
          step();
        end
        chk($sformatf("v%0d_b%0d_valid", v, b), 64'(bus.out_valid), 64'd1);
        chk($sformatf("v%0d_b%0d_inready", v, b), 64'(bus.in_ready), 64'd0);
        chk($sformatf("v%0d_b%0d_off", v, b), 64'(bus.out_offset), 64'(off));
        chk($sformatf("v%0d_b%0d_data", v, b), bus.out_data, word_of(v, off));
        chk($sformatf("v%0d_b%0d_set", v, b), 64'(bus.out_set), 64'(t.set_idx));
        chk($sformatf("v%0d_b%0d_last", v, b), 64'(bus.out_last), 64'(b == t.nbeats - 1));
        bus.out_ready = 1'b1;
        step();
      end
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_done_valid", v), 64'(bus.out_valid), 64'd0);
      chk($sformatf("v%0d_done_last", v), 64'(bus.out_last), 64'd0);
      chk($sformatf("v%0d_done_ready", v), 64'(bus.in_ready), 64'd1);
      chk($sformatf("v%0d_done_err", v), 64'(bus.err_onehot), 64'd0);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{64'h1,             8'hFF, 1'b0, 6'd0,  8, 32'h76543210, 1'b0};
    vecs[1] = '{64'h1 << 63,       8'hA4, 1'b0, 6'd63, 3, 32'h00000752, 1'b0};
    vecs[2] = '{64'h1 << 10,       8'h81, 1'b0, 6'd10, 2, 32'h00000070, 1'b1};
    vecs[3] = '{64'h3,             8'hFF, 1'b1, 6'd0,  0, 32'h0,        1'b0};
    vecs[4] = '{64'h0,             8'hFF, 1'b1, 6'd0,  0, 32'h0,        1'b0};
    vecs[5] = '{64'h1 << 5,        8'h00, 1'b0, 6'd0,  0, 32'h0,        1'b0};
    vecs[6] = '{64'h1 << 6,        8'h02, 1'b0, 6'd6,  1, 32'h00000001, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0001, 8'h00, 1'b1, 6'd0, 0, 32'h0,   1'b0};
    vecs[8] = '{64'h1 << 9,        8'h30, 1'b0, 6'd9,  2, 32'h00000054, 1'b0};

    rst               = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_set_onehot = '0;
    bus.in_word_mask  = '0;
    bus.in_line       = '0;
    bus.out_ready     = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_err", 64'(bus.err_onehot), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_set", 64'(bus.out_set), 64'd0);
    chk("rst_offset", 64'(bus.out_offset), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);

    for (int v = 0; v < 8; v++) run_vec(v);

    // Reset in the middle of a drain, with a beat handshake on the same edge.
    bus.in_valid      = 1'b1;
    bus.in_set_onehot = 64'h1 << 3;
    bus.in_word_mask  = 8'hFF;
    bus.in_line       = make_line(20);
    bus.out_ready     = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("rstseq_b%0d_off", b), 64'(bus.out_offset), 64'(b));
      chk($sformatf("rstseq_b%0d_set", b), 64'(bus.out_set), 64'd3);
      step();
    end
    chk("rstseq_b3_off", 64'(bus.out_offset), 64'd3);
    rst = 1'b1;
    step();
    chk("rstseq_valid", 64'(bus.out_valid), 64'd0);
    chk("rstseq_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rstseq_err", 64'(bus.err_onehot), 64'd0);
    chk("rstseq_last", 64'(bus.out_last), 64'd0);
    chk("rstseq_set", 64'(bus.out_set), 64'd0);
    rst = 1'b0;
    run_vec(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
